// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma letter sequencer: FSM state encoding,
// reflector wiring, alphabet size and mod-26 arithmetic helpers.
package enigma_pkg;

  localparam int unsigned ALPHA = 26;

  // Reflector B, one ASCII letter per byte, index 0 ('A') in the top byte.
  localparam logic [8*ALPHA-1:0] REFLECTOR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [3:0] {
    IDLE,
    STEP,
    F_R,
    F_M,
    F_L,
    REFL,
    B_L,
    B_M,
    B_R,
    DONE
  } state_t;

  // (a + b) mod 26 for a, b in 0..25, done in 6 bits.
  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[4:0];
  endfunction

  // (a - b) mod 26 for a, b in 0..25, done in 6 bits.
  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'(ALPHA);
    return s[4:0];
  endfunction

  // Letter index (0..25) stored at position i of a 26-character wiring string.
  function automatic logic [4:0] letter_at(input logic [8*ALPHA-1:0] s, input logic [4:0] i);
    logic [7:0] ch;
    logic [7:0] base;
    ch   = '0;
    base = '0;
    if (i > 5'(ALPHA - 1)) return '0;
    base = 8'(8 * (ALPHA - 1 - 32'(i)));
    ch   = s[base +: 8];
    return 5'(ch - 8'd65);
  endfunction

  // Start positions outside the alphabet load as 0.
  function automatic logic [4:0] clip_pos(input logic [4:0] p);
    return (p > 5'(ALPHA - 1)) ? '0 : p;
  endfunction

endpackage

// File: rtl/enigma_sequencer_rotor.sv
// Rotor wiring lookup: rotors I..VIII. REVERSE=0 gives the forward
// wiring, REVERSE=1 gives its inverse. Purely combinational.
module enigma_sequencer_rotor
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_TYPES = 8,
  parameter bit          REVERSE   = 1'b0
) (
  input  logic [2:0] type_i,
  input  logic [4:0] idx_i,
  output logic [4:0] code_o
);

  function automatic logic [8*ALPHA-1:0] wiring(input logic [2:0] t);
    logic [8*ALPHA-1:0] w;
    case (t)
      3'd0:    w = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
      3'd1:    w = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
      3'd2:    w = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
      3'd3:    w = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
      3'd4:    w = "VZBRGITYUPSDNHLXAWMJQOFECK";
      3'd5:    w = "JPGVOUMFYQBENHZRDKASXLICTW";
      3'd6:    w = "NZJHGRCXMYSWBOUFAIVLPEKQDT";
      default: w = "FKQHTLXOCBJSPDZRAMEWNIYGVU";
    endcase
    return w;
  endfunction

  logic [2:0]         type_sel;
  logic [8*ALPHA-1:0] wire_str;

  // Forward: direct table read. Reverse: search for the entry equal to idx_i.
  always_comb begin
    type_sel = (32'(type_i) < NUM_TYPES) ? type_i : '0;
    wire_str = wiring(type_sel);
    code_o   = '0;
    if (!REVERSE) begin
      code_o = letter_at(wire_str, idx_i);
    end else begin
      for (int unsigned j = 0; j < ALPHA; j++) begin
        if (letter_at(wire_str, 5'(j)) == idx_i) code_o = 5'(j);
      end
    end
  end

endmodule

// File: rtl/enigma_sequencer.sv
// Enigma letter sequencer: three-rotor cipher processed one stage per cycle
// (step, three forward passes, reflector, three reverse passes).
// Optional build macro ENIGMA_DOUBLE_STEP_EN enables the historical
// middle-rotor double step; undefined gives a pure odometer.
module enigma_sequencer
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_TYPES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [2:0] cfg_type_l,
  input  logic [2:0] cfg_type_m,
  input  logic [2:0] cfg_type_r,
  input  logic [4:0] cfg_pos_l,
  input  logic [4:0] cfg_pos_m,
  input  logic [4:0] cfg_pos_r,
  input  logic       in_valid,
  input  logic [4:0] in_code,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] out_code,
  output logic       out_err,
  input  logic       out_ready,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [2:0] type_l_q, type_l_d, type_m_q, type_m_d, type_r_q, type_r_d;
  logic [4:0] pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
  logic [4:0] code_q, code_d;
  logic       err_q, err_d;

  logic [2:0] slot_type;
  logic [4:0] slot_pos;
  logic [4:0] lut_idx;
  logic [4:0] fwd_code;
  logic [4:0] rev_code;
  logic       step_m;
  logic       step_l;

  // Pick the rotor slot the current pass works on and its offset input.
  always_comb begin
    slot_type = type_r_q;
    slot_pos  = pos_r_q;
    case (state_q)
      F_M, B_M: begin
        slot_type = type_m_q;
        slot_pos  = pos_m_q;
      end
      F_L, B_L: begin
        slot_type = type_l_q;
        slot_pos  = pos_l_q;
      end
      default: ;
    endcase
    lut_idx = mod26_add(code_q, slot_pos);
  end

  enigma_sequencer_rotor #(
    .NUM_TYPES (NUM_TYPES),
    .REVERSE   (1'b0)
  ) u_fwd (
    .type_i (slot_type),
    .idx_i  (lut_idx),
    .code_o (fwd_code)
  );

  enigma_sequencer_rotor #(
    .NUM_TYPES (NUM_TYPES),
    .REVERSE   (1'b1)
  ) u_rev (
    .type_i (slot_type),
    .idx_i  (lut_idx),
    .code_o (rev_code)
  );

  // Rotor advance conditions for the STEP state.
  always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
    step_m = (pos_r_q == 5'(ALPHA - 1)) || (pos_m_q == 5'(ALPHA - 1));
`else
    step_m = (pos_r_q == 5'(ALPHA - 1));
`endif
    step_l = step_m && (pos_m_q == 5'(ALPHA - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one stage per cycle, IDLE and DONE wait on handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cfg_load && in_valid) state_d = STEP;
      STEP:    state_d = err_q ? DONE : F_R;
      F_R:     state_d = F_M;
      F_M:     state_d = F_L;
      F_L:     state_d = REFL;
      REFL:    state_d = B_L;
      B_L:     state_d = B_M;
      B_M:     state_d = B_R;
      B_R:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready  = (state_q == IDLE) && !cfg_load;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_code  = code_q;
    out_err   = err_q;
    pos_l     = pos_l_q;
    pos_m     = pos_m_q;
    pos_r     = pos_r_q;
  end

  // Datapath next values: configuration, stepping and per-stage substitution.
  always_comb begin
    type_l_d = type_l_q;
    type_m_d = type_m_q;
    type_r_d = type_r_q;
    pos_l_d  = pos_l_q;
    pos_m_d  = pos_m_q;
    pos_r_d  = pos_r_q;
    code_d   = code_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          type_l_d = cfg_type_l;
          type_m_d = cfg_type_m;
          type_r_d = cfg_type_r;
          pos_l_d  = clip_pos(cfg_pos_l);
          pos_m_d  = clip_pos(cfg_pos_m);
          pos_r_d  = clip_pos(cfg_pos_r);
        end else if (in_valid) begin
          code_d = in_code;
          err_d  = (in_code > 5'(ALPHA - 1));
        end
      end
      STEP: begin
        if (!err_q) begin
          pos_r_d = mod26_add(pos_r_q, 5'd1);
          if (step_m) pos_m_d = mod26_add(pos_m_q, 5'd1);
          if (step_l) pos_l_d = mod26_add(pos_l_q, 5'd1);
        end
      end
      F_R, F_M, F_L: code_d = mod26_sub(fwd_code, slot_pos);
      REFL:          code_d = letter_at(REFLECTOR, code_q);
      B_L, B_M, B_R: code_d = mod26_sub(rev_code, slot_pos);
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_l_q <= '0;
      type_m_q <= '0;
      type_r_q <= '0;
      pos_l_q  <= '0;
      pos_m_q  <= '0;
      pos_r_q  <= '0;
      code_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      type_l_q <= type_l_d;
      type_m_q <= type_m_d;
      type_r_q <= type_r_d;
      pos_l_q  <= pos_l_d;
      pos_m_q  <= pos_m_d;
      pos_r_q  <= pos_r_d;
      code_q   <= code_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/enigma_sequencer.md
ENIGMA_SEQUENCER -- requirements
Module: enigma_sequencer

Interface
REQ-001 SHALL have parameter NUM_TYPES, default 8, meaning the number of selectable rotor wirings (rotor type field is 3 bits).
REQ-002 SHALL have ports, in order: clk in 1 system clock; reset in 1 sync active-high reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have cfg_load in 1, load rotor types/positions (IDLE only).
REQ-004 SHALL have cfg_type_l/cfg_type_m/cfg_type_r in 3 each, rotor type per slot (left/middle/right).
REQ-005 SHALL have cfg_pos_l/cfg_pos_m/cfg_pos_r in 5 each, start positions 0..25.
REQ-006 SHALL have in_valid in 1, in_code in 5, in_ready out 1, letter input handshake.
REQ-007 SHALL have out_valid out 1, out_code out 5, out_err out 1, out_ready in 1, result handshake.
REQ-008 SHALL have pos_l/pos_m/pos_r out 5 each, current rotor positions; busy out 1, high when not IDLE.

Function
REQ-009 SHALL use FSM states IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, DONE, one state per cycle, except IDLE and DONE, which wait.
REQ-010 SHALL set in_ready = (state==IDLE) && !cfg_load; an input handshake moves IDLE->STEP and registers in_code.
REQ-011 SHALL, in IDLE, give cfg_load priority over in_valid: it registers all types/positions, and cfg_pos values >25 load as 0; cfg_load outside IDLE SHALL be ignored.
REQ-012 SHALL, in STEP, advance the right rotor mod 26; if pos_r was 25 before stepping, the middle rotor also advances; if the middle wraps 25->0, the left rotor advances.
REQ-013 SHALL, in F_R/F_M/F_L, apply a forward wiring lookup with offset: c' = (W_fwd[type][(c+pos) mod 26] - pos) mod 26; all mod-26 arithmetic is done in 6 bits with a conditional subtract/add of 26.
REQ-014 SHALL, in REFL, map c through the fixed reflector YRUHQSLDPXNGOKMIEBFZCWVJAT (A=0 maps to Y=24, and so on).
REQ-015 SHALL, in B_L/B_M/B_R, apply the same offset rule using the reverse (inverse) wiring tables.
REQ-016 SHALL time-share a single forward and a single reverse lookup instance, selected by the state's slot type.
REQ-017 SHALL, in DONE, hold out_valid=1 with a stable out_code until out_ready; it then returns to IDLE on that edge; result latency is 9 cycles from input handshake to out_valid.
REQ-018 SHALL, if in_code >25: skip STEP and lookups (STEP->DONE directly), leave positions unchanged, output out_code=in_code, out_err=1; out_err=0 otherwise.
REQ-019 SHALL treat out_ready asserted before DONE as having no effect.

Reset
REQ-020 SHALL, on reset, set state=IDLE, out_valid=0, out_code=0, out_err=0, busy=0, all types=0, all positions=0; reset mid-operation SHALL abort the letter with no output.

Configuration
REQ-021 SHALL support macro ENIGMA_DOUBLE_STEP_EN: when defined, in STEP, a middle rotor at 25 before stepping advances itself and the left rotor (historical double step), in addition to REQ-012.
REQ-022 SHALL, when ENIGMA_DOUBLE_STEP_EN is undefined, step as a pure odometer per REQ-012 only.

Structure
REQ-023 SHALL place state enum, reflector constant, ALPHA=26 and a mod-26 add/sub function in shared package enigma_pkg.
REQ-024 SHALL instantiate the existing rotor wiring lookup twice (forward, reverse) as its sole sub-module; no other sub-module.

Verification
REQ-025 SHALL verify: reset then idle -> out_valid=0, pos 0/0/0, in_ready=1.
REQ-026 SHALL verify: cfg pos r=25,m=0,l=0, one letter -> pos_r=0, pos_m=1, pos_l=0; out_valid exactly 9 cycles after handshake.
REQ-027 SHALL verify: pos m=25,r=0 with ENIGMA_DOUBLE_STEP_EN -> after one letter r=1, m=0, l=1; without the macro -> r=1, m=25, l=0.
REQ-028 SHALL verify: in_code=30 -> out_err=1, out_code=30, positions unchanged.
REQ-029 SHALL verify reciprocity: encode 0 from config X giving y; reload X, encode y -> 0; no output equals its input across 26 letters.
REQ-030 SHALL verify: out_ready held low 5 cycles in DONE -> out_code stable, in_ready=0; cfg_load during F_M -> ignored.
